// File: rtl/pipeline_hazard_scheduler.sv
// ============================================================================
// Module   : pipeline_hazard_scheduler
// Purpose  : Merges hazard requests into per-stage stall/flush enables and
//            sequences a drain-then-freeze halt. Optional perf counters are
//            built when PERF_CNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_scheduler #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_busy,
  input  logic             load_use_hazard,
  input  logic             branch_hazard,
  input  logic             branch_flushD,
  input  logic             halt_req,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [3:0] c_drain_load = 4'(DRAIN_CYCLES - 1);
  localparam logic [3:0] c_drain_one  = 4'd1;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_drain_cnt;
  logic [3:0] w_drain_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    stallF      = 1'b0;
    stallD      = 1'b0;
    stallE      = 1'b0;
    stallM      = 1'b0;
    flushD      = 1'b0;
    flushE      = 1'b0;
    halted      = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (mem_busy) begin
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          stallM = 1'b1;
        end else if (load_use_hazard || branch_hazard) begin
          // The stalled instruction is re-presented, so halt/branch wait a cycle.
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end else if (halt_req) begin
          stallF      = 1'b1;
          flushD      = 1'b1;
          w_drain_nxt = c_drain_load;
          w_state_nxt = ST_DRAIN;
        end else if (branch_flushD) begin
          flushD = 1'b1;
        end
      end

      ST_DRAIN: begin
        if (mem_busy) begin
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          stallM = 1'b1;
        end else begin
          // Bubbles enter ID while the older instructions retire.
          stallF = 1'b1;
          flushD = 1'b1;
          if (r_drain_cnt == 4'd0) begin
            w_state_nxt = ST_HALTED;
          end else begin
            w_drain_nxt = r_drain_cnt - c_drain_one;
          end
        end
      end

      ST_HALTED: begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        halted = 1'b1;
      end

      default: begin
        w_state_nxt = ST_RUN;
        w_drain_nxt = 4'd0;
      end
    endcase
  end

`ifdef PERF_CNT_EN
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_any_stall;
  logic             w_any_flush;

  // A frozen core is not charged as stall time.
  assign w_any_stall = (stallF | stallD | stallE | stallM) & (r_state != ST_HALTED);
  assign w_any_flush = flushD | flushE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_any_stall) begin
        r_stall_cnt <= r_stall_cnt + c_cnt_one;
      end
      if (w_any_flush) begin
        r_flush_cnt <= r_flush_cnt + c_cnt_one;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire
